prbs9_ber_ctrl: RTL and testbench



---
 rtl/prbs9_ber_ctrl.sv | 131 +++++++++++++
 tb/tb_prbs9_ber_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs9_ber_ctrl.sv
// PRBS9 bit-error-rate controller: slips an external prbs9 reference into alignment
// with the received stream, then counts errors over fixed windows while locked.
module prbs9_ber_ctrl #(
  parameter int LOCK_CNT = 32,
  parameter int WIN_W    = 10,
  parameter int LOSS_THR = 64
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_enable,
  input  logic             i_valid,
  input  logic             i_rx_bit,
  input  logic             i_prbs_bit,
  output logic             o_prbs_rst,
  output logic             o_prbs_en,
  output logic             o_lock,
  output logic [WIN_W:0]   o_err_cnt,
  output logic             o_win_done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    LOCKED = 2'd2
  } state_e;

  localparam logic [7:0]     LOCK_LAST = 8'(LOCK_CNT - 1);
  localparam logic [WIN_W:0] LOSS_LIM  = LOSS_THR[WIN_W:0];

  state_e             state_q, state_d;
  logic [7:0]         match_cnt_q, match_cnt_d;
  logic [WIN_W-1:0]   samp_cnt_q, samp_cnt_d;
  logic [WIN_W:0]     err_acc_q, err_acc_d;
  logic [WIN_W:0]     err_cnt_q, err_cnt_d;
  logic               win_done_q, win_done_d;

  logic               miss;
  logic               win_end;
  logic [WIN_W:0]     win_sum;

  assign miss    = i_rx_bit ^ i_prbs_bit;
  assign win_end = (state_q == LOCKED) && i_valid && (samp_cnt_q == {WIN_W{1'b1}});
  // The final sample of a window is folded in here so it is never lost at the boundary.
  assign win_sum = err_acc_q + {{WIN_W{1'b0}}, miss};

  always_comb begin
    state_d     = state_q;
    match_cnt_d = match_cnt_q;
    samp_cnt_d  = samp_cnt_q;
    err_acc_d   = err_acc_q;
    err_cnt_d   = err_cnt_q;
    win_done_d  = 1'b0;

    // A window that completes on the same sample as a disable is still reported.
    if (win_end) begin
      err_cnt_d  = win_sum;
      win_done_d = 1'b1;
    end

    if (!i_enable) begin
      state_d     = IDLE;
      match_cnt_d = '0;
      samp_cnt_d  = '0;
      err_acc_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d     = SEARCH;
          match_cnt_d = '0;
        end
        SEARCH: begin
          if (i_valid) begin
            if (miss) begin
              match_cnt_d = '0;
            end else if (match_cnt_q == LOCK_LAST) begin
              state_d     = LOCKED;
              match_cnt_d = '0;
              samp_cnt_d  = '0;
              err_acc_d   = '0;
            end else begin
              match_cnt_d = match_cnt_q + 8'd1;
            end
          end
        end
        LOCKED: begin
          if (i_valid) begin
            samp_cnt_d = samp_cnt_q + WIN_W'(1);
            if (win_end) begin
              err_acc_d = '0;
              if (win_sum > LOSS_LIM) begin
                state_d     = SEARCH;
                match_cnt_d = '0;
              end
            end else begin
              err_acc_d = win_sum;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      match_cnt_q <= '0;
      samp_cnt_q  <= '0;
      err_acc_q   <= '0;
      err_cnt_q   <= '0;
      win_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      match_cnt_q <= match_cnt_d;
      samp_cnt_q  <= samp_cnt_d;
      err_acc_q   <= err_acc_d;
      err_cnt_q   <= err_cnt_d;
      win_done_q  <= win_done_d;
    end
  end

  // A mismatch while searching holds the reference for that sample: a one-bit slip.
  assign o_prbs_en  = i_valid && ((state_q == LOCKED) || ((state_q == SEARCH) && !miss));
  assign o_prbs_rst = (state_q == IDLE);
  assign o_lock     = (state_q == LOCKED);
  assign o_err_cnt  = err_cnt_q;
  assign o_win_done = win_done_q;

endmodule

// File: tb/tb_prbs9_ber_ctrl.sv
// Bench for prbs9_ber_ctrl: models the reference prbs9 and a second rx prbs9 (x^9+x^5+1),
// checks combinational outputs from a vector table and lock/window behaviour by sequence.
module tb_prbs9_ber_ctrl;

  localparam logic [8:0] SEED = 9'h1AA;

  logic        clk;
  logic        i_rst_n;
  logic        i_enable;
  logic        i_valid;
  logic        i_rx_bit;
  logic        i_prbs_bit;
  logic        o_prbs_rst;
  logic        o_prbs_en;
  logic        o_lock;
  logic [10:0] o_err_cnt;
  logic        o_win_done;

  logic        validOn;
  logic        gapMode;
  logic [6:0]  gapLfsr = 7'h2B;
  logic        rxRst;
  logic [8:0]  rxSeed;
  logic [8:0]  rxLfsr;
  logic [8:0]  refLfsr;
  logic        rxZero;
  logic        rxForceEn;
  logic        rxForceVal;
  logic        rxFlip;
  int          flipA, flipB, flipC;
  int          sampCount = 0;
  int          slips = 0;
  int          enViol = 0;
  int          checkCount = 0;
  int          passCount = 0;

  typedef struct {
    int   stage;
    logic valid;
    logic match;
    logic expEn;
    logic expRst;
    logic expLock;
  } vec_t;
  vec_t tbl[9];

  prbs9_ber_ctrl dut (
    .clk        (clk),
    .i_rst_n    (i_rst_n),
    .i_enable   (i_enable),
    .i_valid    (i_valid),
    .i_rx_bit   (i_rx_bit),
    .i_prbs_bit (i_prbs_bit),
    .o_prbs_rst (o_prbs_rst),
    .o_prbs_en  (o_prbs_en),
    .o_lock     (o_lock),
    .o_err_cnt  (o_err_cnt),
    .o_win_done (o_win_done)
  );

  function automatic logic [8:0] prbsNext(input logic [8:0] s);
    return {s[7:0], s[8] ^ s[4]};
  endfunction

  function automatic logic [8:0] prbsAdv(input logic [8:0] s0, input int n);
    logic [8:0] s;
    s = s0;
    for (int k = 0; k < n; k++) s = prbsNext(s);
    return s;
  endfunction

  function automatic int onesCount(input logic [8:0] s0, input int n);
    logic [8:0] s;
    int c;
    s = s0;
    c = 0;
    for (int k = 0; k < n; k++) begin
      c += int'(s[8]);
      s = prbsNext(s);
    end
    return c;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference generator owned by the DUT, and the independent rx-side generator.
  always_ff @(posedge clk) begin
    if (o_prbs_rst) refLfsr <= SEED;
    else if (o_prbs_en && i_valid) refLfsr <= prbsNext(refLfsr);
  end

  always_ff @(posedge clk) begin
    if (rxRst) rxLfsr <= rxSeed;
    else if (i_valid) rxLfsr <= prbsNext(rxLfsr);
  end

  always @(negedge clk) gapLfsr = {gapLfsr[5:0], gapLfsr[6] ^ gapLfsr[5]};

  assign i_valid    = validOn && (!gapMode || gapLfsr[0]);
  assign i_prbs_bit = refLfsr[8];
  assign rxFlip     = ((sampCount + 1) == flipA) || ((sampCount + 1) == flipB) ||
                      ((sampCount + 1) == flipC);
  assign i_rx_bit   = rxForceEn ? rxForceVal : (rxZero ? 1'b0 : (rxLfsr[8] ^ rxFlip));

  always @(posedge clk) if (i_valid) sampCount++;

  always begin
    @(negedge clk);
    #1;
    if (!i_valid && o_prbs_en) enViol++;
    if (i_valid && i_enable && !o_lock && !o_prbs_rst && (i_rx_bit != i_prbs_bit)) slips++;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic applyStimulus(input int stage);
    logic savedValid;
    savedValid = validOn;
    for (int i = 0; i < 9; i++) begin
      if (tbl[i].stage == stage) begin
        validOn    = tbl[i].valid;
        rxForceEn  = 1'b1;
        rxForceVal = tbl[i].match ? i_prbs_bit : ~i_prbs_bit;
        #1;
        checkOutput($sformatf("tbl%0d prbs_en", i), o_prbs_en, tbl[i].expEn);
        checkOutput($sformatf("tbl%0d prbs_rst", i), o_prbs_rst, tbl[i].expRst);
        checkOutput($sformatf("tbl%0d lock", i), o_lock, tbl[i].expLock);
      end
    end
    validOn   = savedValid;
    rxForceEn = 1'b0;
  endtask

  task automatic startRun(input logic [8:0] seed, input bit doTable, output int base);
    i_enable = 1'b0;
    validOn  = 1'b0;
    rxRst    = 1'b1;
    rxSeed   = seed;
    rxZero   = 1'b0;
    flipA    = -1;
    flipB    = -1;
    flipC    = -1;
    @(negedge clk);
    @(negedge clk);
    i_enable = 1'b1;
    @(negedge clk);
    if (doTable) applyStimulus(1);
    rxRst   = 1'b0;
    slips   = 0;
    base    = sampCount;
    validOn = 1'b1;
  endtask

  task automatic waitLock(input int maxCyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxCyc; i++) begin
      @(negedge clk);
      if (o_lock) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic waitWinDone(input int maxCyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxCyc; i++) begin
      @(negedge clk);
      if (o_win_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    int base, lockAt, expErr;
    bit ok, prevLock, seen;

    tbl[0] = '{0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[7] = '{2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[8] = '{2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    i_rst_n = 1'b0; i_enable = 1'b0; validOn = 1'b1; gapMode = 1'b0;
    rxRst = 1'b1; rxSeed = SEED; rxZero = 1'b0; rxForceEn = 1'b0; rxForceVal = 1'b0;
    flipA = -1; flipB = -1; flipC = -1;

    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset lock", o_lock, 0);
    checkOutput("reset err_cnt", o_err_cnt, 0);
    checkOutput("reset win_done", o_win_done, 0);
    checkOutput("reset prbs_rst", o_prbs_rst, 1);
    checkOutput("reset prbs_en", o_prbs_en, 0);
    validOn = 1'b0;
    @(negedge clk);
    i_rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(0);

    $display("[TB] aligned stream");
    startRun(SEED, 1'b1, base);
    waitLock(200, ok);
    checkOutput("aligned lock seen", ok, 1);
    checkOutput("aligned lock samples", sampCount - base, 32);
    applyStimulus(2);
    lockAt = sampCount;
    for (int w = 1; w <= 2; w++) begin
      waitWinDone(1100, ok);
      checkOutput("aligned win_done seen", ok, 1);
      checkOutput("aligned window length", sampCount - lockAt, 1024 * w);
      checkOutput("aligned err_cnt", o_err_cnt, 0);
      checkOutput("aligned lock held", o_lock, 1);
    end
    @(negedge clk);
    checkOutput("win_done single cycle", o_win_done, 0);

    $display("[TB] offset stream");
    startRun(prbsAdv(SEED, 5), 1'b0, base);
    waitLock(6000, ok);
    checkOutput("offset lock seen", ok, 1);
    checkOutput("offset slips occurred", slips > 0, 1);
    checkOutput("offset lock bound", (sampCount - base) <= (543 + 32 * slips), 1);
    waitWinDone(1100, ok);
    checkOutput("offset win_done seen", ok, 1);
    checkOutput("offset err_cnt", o_err_cnt, 0);
    checkOutput("offset lock held", o_lock, 1);

    $display("[TB] injected errors");
    startRun(SEED, 1'b0, base);
    waitLock(200, ok);
    checkOutput("inject lock seen", ok, 1);
    lockAt = sampCount;
    flipA = lockAt + 100; flipB = lockAt + 500; flipC = lockAt + 1024;
    waitWinDone(1100, ok);
    checkOutput("inject win_done seen", ok, 1);
    checkOutput("inject window length", sampCount - lockAt, 1024);
    checkOutput("inject err_cnt", o_err_cnt, 3);
    checkOutput("inject lock held", o_lock, 1);
    waitWinDone(1100, ok);
    checkOutput("inject next err_cnt", o_err_cnt, 0);
    checkOutput("inject next lock held", o_lock, 1);
    flipA = -1; flipB = -1; flipC = -1;

    $display("[TB] loss of lock");
    startRun(SEED, 1'b0, base);
    waitLock(200, ok);
    checkOutput("loss lock seen", ok, 1);
    rxZero = 1'b1;
    expErr = onesCount(prbsAdv(SEED, 32), 1024);
    seen = 1'b0;
    prevLock = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      prevLock = o_lock;
      @(negedge clk);
      if (o_win_done) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("loss win_done seen", seen, 1);
    checkOutput("loss err_cnt", o_err_cnt, expErr);
    checkOutput("loss err over thr", o_err_cnt > 64, 1);
    checkOutput("loss lock before", prevLock, 1);
    checkOutput("loss lock dropped", o_lock, 0);
    rxZero = 1'b0;
    waitLock(6000, ok);
    checkOutput("relock after loss", ok, 1);

    $display("[TB] reset and enable");
    repeat (200) @(negedge clk);
    checkOutput("pre-reset lock", o_lock, 1);
    checkOutput("pre-reset err_cnt", o_err_cnt, expErr);
    i_rst_n = 1'b0;
    #1;
    checkOutput("async reset lock", o_lock, 0);
    checkOutput("async reset err_cnt", o_err_cnt, 0);
    checkOutput("async reset win_done", o_win_done, 0);
    checkOutput("async reset prbs_rst", o_prbs_rst, 1);
    @(negedge clk);
    i_enable = 1'b0;
    i_rst_n = 1'b1;
    startRun(SEED, 1'b0, base);
    repeat (20) @(negedge clk);
    checkOutput("mid-search lock", o_lock, 0);
    i_enable = 1'b0;
    @(negedge clk);
    checkOutput("disable prbs_rst", o_prbs_rst, 1);
    checkOutput("disable lock", o_lock, 0);
    startRun(SEED, 1'b0, base);
    waitLock(200, ok);
    checkOutput("re-enable lock seen", ok, 1);
    checkOutput("re-enable lock samples", sampCount - base, 32);

    $display("[TB] window end with disable");
    lockAt = sampCount;
    flipA = lockAt + 1024;
    seen = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      if (sampCount == lockAt + 1023) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("reach last sample", seen, 1);
    i_enable = 1'b0;
    @(negedge clk);
    checkOutput("end+disable win_done", o_win_done, 1);
    checkOutput("end+disable err_cnt", o_err_cnt, 1);
    checkOutput("end+disable lock", o_lock, 0);
    checkOutput("end+disable prbs_rst", o_prbs_rst, 1);
    @(negedge clk);
    checkOutput("end+disable pulse end", o_win_done, 0);
    flipA = -1;

    $display("[TB] valid gaps");
    gapMode = 1'b1;
    startRun(SEED, 1'b0, base);
    waitLock(400, ok);
    checkOutput("gap lock seen", ok, 1);
    checkOutput("gap lock samples", sampCount - base, 32);
    lockAt = sampCount;
    waitWinDone(4000, ok);
    checkOutput("gap win_done seen", ok, 1);
    checkOutput("gap window length", sampCount - lockAt, 1024);
    checkOutput("gap err_cnt", o_err_cnt, 0);
    checkOutput("gap lock held", o_lock, 1);
    gapMode = 1'b0;
    checkOutput("prbs_en without valid", enViol, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
